// File: rtl/midi_merge_arb.sv
// midi_merge_arb
//   Merges MIDI byte streams from N_CH receive channels into one byte stream
//   for an output FIFO. Once a channel wins with a status byte it keeps the
//   grant until its message is complete, so bytes of different messages never
//   interleave. Running status is expanded per channel: a data byte that
//   arrives while no message is open re-emits the stored status first.
//   Realtime bytes from other channels may slip in between the owner's bytes.
//   A lock whose owner goes quiet is released by a timeout.
//
// Handshake: a byte moves from channel i when in_valid[i] && in_ready[i] at a
//   rising clk edge. in_ready is combinational from in_valid, at most one bit
//   set, and zero while out_full or reset is high. A byte is never withdrawn
//   by the arbiter once in_ready has been given.
//
// Ports
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   in_valid     per-channel byte present
//   in_data      per-channel byte, channel i in [8i+7:8i]
//   in_ready     per-channel accept (one-hot or zero)
//   out_data     merged byte, valid while out_wr is high
//   out_wr       one-cycle write strobe, one cycle after the accepting edge
//   out_full     FIFO full; blocks every transfer and emission
//   err_drop     pulse: data byte with no message context discarded
//   err_timeout  pulse: owner lock released by timeout
//   dbg_state    current FSM state (IDLE=0, INSERT=1, LOCKED=2, SYSEX=3)
module midi_merge_arb #(
   parameter int N_CH    = 4,
   parameter int TIMEOUT = 50000,
   parameter int TO_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   in_valid,
   input  logic [8*N_CH-1:0] in_data,
   output logic [N_CH-1:0]   in_ready,
   output logic [7:0]        out_data,
   output logic              out_wr,
   input  logic              out_full,
   output logic              err_drop,
   output logic              err_timeout,
   output logic [1:0]        dbg_state
);
   localparam int IW = $clog2(N_CH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_INSERT = 2'd1,
      S_LOCKED = 2'd2,
      S_SYSEX  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [IW-1:0]          rr_q, rr_d;
   logic [1:0]             cnt_q, cnt_d;
   logic [TO_W-1:0]        to_q, to_d;
   // Stored running status per channel; 8'h00 means none (a status always has bit 7 set).
   logic [N_CH-1:0][7:0]   rs_q, rs_d;
   logic [7:0]             out_data_q, out_data_d;
   logic                   out_wr_q, out_wr_d;
   logic                   err_drop_q, err_drop_d;
   logic                   err_to_q, err_to_d;

   logic [N_CH-1:0][7:0]   hd;
   logic [N_CH-1:0]        ready;
   logic                   found, bypass, fire;
   logic [IW-1:0]          g, idx;
   logic [7:0]             b;

   assign hd = in_data;

   // Data bytes that follow a status byte (F0 and realtime never reach here).
   function automatic logic [1:0] data_cnt(input logic [7:0] s);
      logic [1:0] n;
      n = 2'd2;
      if (s[7:4] == 4'hC || s[7:4] == 4'hD || s == 8'hF1 || s == 8'hF3)
         n = 2'd1;
      else if (s[7:4] == 4'hF && s != 8'hF2)
         n = 2'd0;
      return n;
   endfunction

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_d       = rr_q;
      cnt_d      = cnt_q;
      to_d       = '0;
      rs_d       = rs_q;
      out_data_d = out_data_q;
      out_wr_d   = 1'b0;
      err_drop_d = 1'b0;
      err_to_d   = 1'b0;
      ready      = '0;
      found      = 1'b0;
      bypass     = 1'b0;
      fire       = 1'b0;
      g          = '0;
      idx        = '0;
      b          = 8'h00;

      if (!out_full) begin
         case (state_q)
            S_IDLE: begin
               // Round robin starting one past the last granted channel.
               for (int k = 1; k <= N_CH; k++) begin
                  idx = IW'((int'(rr_q) + k) % N_CH);
                  if (!found && in_valid[idx]) begin
                     found = 1'b1;
                     g     = idx;
                  end
               end
            end
            S_LOCKED, S_SYSEX: begin
               // Realtime from another channel jumps ahead of the owner.
               for (int i = 0; i < N_CH; i++) begin
                  if (!bypass && IW'(i) != owner_q && in_valid[i] && hd[i][7:3] == 5'b11111) begin
                     bypass = 1'b1;
                     g      = IW'(i);
                  end
               end
               if (!bypass)
                  g = owner_q;
               found = bypass || in_valid[owner_q];
               // Owner idle time; a bypass byte does not count as owner activity.
               if (!bypass && in_valid[owner_q])
                  to_d = '0;
               else if (to_q == TO_W'(TIMEOUT - 1))
                  fire = 1'b1;
               else
                  to_d = to_q + TO_W'(1);
               // The timeout cycle owns the output slot (SYSEX closes with F7).
               if (fire)
                  found = 1'b0;
            end
            default: ;
         endcase
      end

      if (fire) begin
         err_to_d        = 1'b1;
         rs_d[owner_q]   = 8'h00;
         state_d         = S_IDLE;
         if (state_q == S_SYSEX) begin
            out_wr_d   = 1'b1;
            out_data_d = 8'hF7;
         end
      end

      if (state_q == S_INSERT && !out_full) begin
         out_wr_d   = 1'b1;
         out_data_d = rs_q[owner_q];
         cnt_d      = data_cnt(rs_q[owner_q]);
         state_d    = S_LOCKED;
      end

      if (found) begin
         b        = hd[g];
         ready[g] = 1'b1;
         if (state_q == S_IDLE)
            rr_d = g;
         if (b >= 8'hF8) begin
            out_wr_d   = 1'b1;
            out_data_d = b;
         end else if (b == 8'hF0) begin
            out_wr_d   = 1'b1;
            out_data_d = b;
            rs_d[g]    = 8'h00;
            owner_d    = g;
            state_d    = S_SYSEX;
         end else if (b[7]) begin
            // Voice or common status, also an implicit end of an open message.
            out_wr_d   = 1'b1;
            out_data_d = b;
            rs_d[g]    = (b < 8'hF0) ? b : 8'h00;
            owner_d    = g;
            cnt_d      = data_cnt(b);
            state_d    = (data_cnt(b) == 2'd0) ? S_IDLE : S_LOCKED;
         end else if (state_q == S_IDLE) begin
            if (rs_q[g] != 8'h00) begin
               // Leave the data byte in place; the stored status goes out first.
               ready[g] = 1'b0;
               owner_d  = g;
               state_d  = S_INSERT;
            end else begin
               err_drop_d = 1'b1;
            end
         end else if (state_q == S_SYSEX) begin
            out_wr_d   = 1'b1;
            out_data_d = b;
         end else begin
            out_wr_d   = 1'b1;
            out_data_d = b;
            cnt_d      = cnt_q - 2'd1;
            if (cnt_q == 2'd1)
               state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         owner_q    <= '0;
         rr_q       <= '0;
         cnt_q      <= 2'd0;
         to_q       <= '0;
         rs_q       <= '0;
         out_data_q <= 8'h00;
         out_wr_q   <= 1'b0;
         err_drop_q <= 1'b0;
         err_to_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
         to_q       <= to_d;
         rs_q       <= rs_d;
         out_data_q <= out_data_d;
         out_wr_q   <= out_wr_d;
         err_drop_q <= err_drop_d;
         err_to_q   <= err_to_d;
      end
   end

   assign in_ready    = ready & ~{N_CH{reset}};
   assign out_data    = out_data_q;
   assign out_wr      = out_wr_q;
   assign err_drop    = err_drop_q;
   assign err_timeout = err_to_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_midi_merge_arb.sv
// Bench for midi_merge_arb: per-channel source queues feed the inputs, a
// scoreboard queue holds the expected merged bytes, and directed checks cover
// reset, arbitration order, running status, realtime bypass, timeout,
// back-pressure and reset in mid-message.
module tb_midi_merge_arb;
   localparam int N_CH    = 4;
   localparam int TIMEOUT = 20;
   localparam int TO_W    = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [N_CH-1:0]   in_valid;
   logic [8*N_CH-1:0] in_data;
   logic [N_CH-1:0]   in_ready;
   logic [7:0]        out_data;
   logic              out_wr;
   logic              out_full;
   logic              err_drop;
   logic              err_timeout;
   logic [1:0]        dbg_state;

   always #5 clk = ~clk;

   midi_merge_arb #(.N_CH(N_CH), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_wr      (out_wr),
      .out_full    (out_full),
      .err_drop    (err_drop),
      .err_timeout (err_timeout),
      .dbg_state   (dbg_state)
   );

   logic [7:0] src_q [N_CH][$];
   logic [7:0] exp_q [$];
   int         total = 0;
   int         bad = 0;
   int         n_drop = 0;
   int         n_to = 0;
   int         cyc = 0;
   int         last_wr_cyc = 0;
   int         to_gap = 0;
   logic       lat_en = 1'b0;
   logic       prev_xfer = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic send(input int ch, input logic [7:0] v);
      src_q[ch].push_back(v);
   endtask

   task automatic expect_b(input logic [7:0] v);
      exp_q.push_back(v);
   endtask

   function automatic bit src_busy();
      for (int c = 0; c < N_CH; c++)
         if (src_q[c].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || src_busy()) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < 300), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   // Driver + monitor: sample on the falling edge, update inputs just after the rising edge.
   initial begin
      logic [N_CH-1:0] xfer;
      in_valid = '0;
      in_data  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (err_timeout) begin
            n_to++;
            to_gap = cyc - last_wr_cyc;
         end
         if (err_drop) n_drop++;
         if (lat_en && prev_xfer) chk("lat_wr", 32'(out_wr), 32'd1);
         if (out_wr) begin
            last_wr_cyc = cyc;
            chk("out_exp_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("out_byte", 32'(out_data), 32'(exp_q.pop_front()));
         end
         chk("rdy_onehot", 32'($onehot0(in_ready)), 32'd1);
         chk("rdy_full", 32'(in_ready & {N_CH{out_full}}), 32'd0);
         xfer      = in_valid & in_ready;
         prev_xfer = |xfer;
         @(posedge clk);
         #1;
         for (int c = 0; c < N_CH; c++) begin
            if (xfer[c] && src_q[c].size() != 0) void'(src_q[c].pop_front());
            if (src_q[c].size() != 0) begin
               in_valid[c]       = 1'b1;
               in_data[8*c +: 8] = src_q[c][0];
            end else begin
               in_valid[c]       = 1'b0;
               in_data[8*c +: 8] = 8'h00;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      out_full = 1'b0;
      // A byte waits on ch0 during reset; it must not be accepted until release.
      send(0, 8'hF8);
      expect_b(8'hF8);
      repeat (3) @(negedge clk);
      chk("rst_valid_seen", 32'(in_valid[0]), 32'd1);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_out_wr", 32'(out_wr), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'h00);
      chk("rst_err_drop", 32'(err_drop), 32'd0);
      chk("rst_err_to", 32'(err_timeout), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      wait_drain("t0_drain");

      // 1: single voice message on ch0
      lat_en = 1'b1;
      send(0, 8'h90); send(0, 8'h3C); send(0, 8'h40);
      expect_b(8'h90); expect_b(8'h3C); expect_b(8'h40);
      wait_drain("t1_drain");
      chk("t1_state", 32'(dbg_state), 32'd0);

      // 2: move rr to ch3, then two simultaneous messages, then rr order check
      send(3, 8'hF8);
      expect_b(8'hF8);
      wait_drain("t2a_drain");
      send(0, 8'h90); send(0, 8'h3C); send(0, 8'h40);
      send(1, 8'hB0); send(1, 8'h07); send(1, 8'h64);
      expect_b(8'h90); expect_b(8'h3C); expect_b(8'h40);
      expect_b(8'hB0); expect_b(8'h07); expect_b(8'h64);
      wait_drain("t2b_drain");
      send(0, 8'hF8); send(2, 8'hFA);
      expect_b(8'hFA); expect_b(8'hF8);
      wait_drain("t2c_drain");

      // 3: running status on ch2
      send(2, 8'h80); send(2, 8'h3C); send(2, 8'h00); send(2, 8'h3E); send(2, 8'h00);
      expect_b(8'h80); expect_b(8'h3C); expect_b(8'h00);
      expect_b(8'h80); expect_b(8'h3E); expect_b(8'h00);
      wait_drain("t3_drain");
      chk("t3_nodrop", 32'(n_drop), 32'd0);

      // 4: sysex with realtime bypass, then owner stall -> timeout and F7
      lat_en = 1'b0;
      send(0, 8'hF0);
      expect_b(8'hF0);
      wait_drain("t4a_drain");
      chk("t4_sysex_state", 32'(dbg_state), 32'd3);
      send(0, 8'h7E); send(0, 8'h01); send(3, 8'hF8);
      expect_b(8'hF8); expect_b(8'h7E); expect_b(8'h01); expect_b(8'hF7);
      wait_drain("t4b_drain");
      chk("t4_timeouts", 32'(n_to), 32'd1);
      chk("t4_to_gap", 32'(to_gap), 32'(TIMEOUT));
      chk("t4_idle_after", 32'(dbg_state), 32'd0);
      send(0, 8'h40);
      wait_drain("t4c_drain");
      chk("t4_drop", 32'(n_drop), 32'd1);

      // 5: back-pressure mid-message with all channels valid
      lat_en = 1'b1;
      send(1, 8'h90); send(1, 8'h3C); send(1, 8'h40);
      send(0, 8'h91); send(0, 8'h11); send(0, 8'h22);
      send(2, 8'h92); send(2, 8'h33); send(2, 8'h44);
      send(3, 8'h93); send(3, 8'h55); send(3, 8'h66);
      expect_b(8'h90); expect_b(8'h3C); expect_b(8'h40);
      expect_b(8'h92); expect_b(8'h33); expect_b(8'h44);
      expect_b(8'h93); expect_b(8'h55); expect_b(8'h66);
      expect_b(8'h91); expect_b(8'h11); expect_b(8'h22);
      for (int i = 0; i < 50 && src_q[1].size() != 2; i++) begin
         @(posedge clk);
         #2;
      end
      out_full = 1'b1;
      #1;
      chk("t5_ready_now", 32'(in_ready), 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t5_ready_full", 32'(in_ready), 32'd0);
         chk("t5_hold_state", 32'(dbg_state), 32'd2);
         if (i > 0) chk("t5_wr_full", 32'(out_wr), 32'd0);
      end
      @(posedge clk);
      #2;
      out_full = 1'b0;
      wait_drain("t5_drain");
      chk("t5_no_timeout", 32'(n_to), 32'd1);

      // 6: reset while LOCKED, then orphan data byte is dropped
      lat_en = 1'b0;
      send(0, 8'h90); send(0, 8'h3C); send(0, 8'h40);
      expect_b(8'h90);
      for (int i = 0; i < 50 && src_q[0].size() != 1; i++) begin
         @(posedge clk);
         #2;
      end
      chk("t6_pre_wr", 32'(out_wr), 32'd1);
      chk("t6_pre_data", 32'(out_data), 32'h3C);
      chk("t6_pre_ready", 32'(in_ready), 32'b0001);
      reset = 1'b1;
      #1;
      chk("t6_rst_ready", 32'(in_ready), 32'd0);
      chk("t6_rst_wr", 32'(out_wr), 32'd0);
      chk("t6_rst_data", 32'(out_data), 32'h00);
      chk("t6_rst_state", 32'(dbg_state), 32'd0);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      for (int i = 0; i < 50 && n_drop < 2; i++) @(negedge clk);
      chk("t6_drop", 32'(n_drop), 32'd2);
      wait_drain("t6_drain");

      chk("end_exp_left", 32'(exp_q.size()), 32'd0);
      chk("end_timeouts", 32'(n_to), 32'd1);
      chk("end_drops", 32'(n_drop), 32'd2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
